jtag_tap_param: RTL and testbench

//  Parametrised IEEE 1149.1-style test access port for the s9234 test wrapper.

---
 rtl/jtag_tap_param_if.sv | 25 ++
 rtl/jtag_tap_param.sv | 179 +++++++++++++++++
 tb/tb_jtag_tap_param.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_param_if.sv
// rtl/jtag_tap_param_if.sv - TAP serial/parallel signal bundle for jtag_tap_param
interface jtag_tap_param_if #(
    parameter int IR_W    = 4,
    parameter int BSR_LEN = 64
);
    logic               TMS;
    logic               TDI;
    logic               TDO;
    logic               TDO_EN;
    logic [BSR_LEN-1:0] bsr_pi;
    logic [BSR_LEN-1:0] bsr_po;
    logic               bs_en;
    logic [IR_W-1:0]    ir_out;
    logic [3:0]         tap_st;

    modport master (
        output TMS, TDI, bsr_pi,
        input  TDO, TDO_EN, bsr_po, bs_en, ir_out, tap_st
    );

    modport slave (
        input  TMS, TDI, bsr_pi,
        output TDO, TDO_EN, bsr_po, bs_en, ir_out, tap_st
    );
endinterface

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised 1149.1 TAP with IR, bypass, boundary register and optional IDCODE (JTAG_IDCODE_EN)
module jtag_tap_param #(
    parameter int              IR_W       = 4,
    parameter int              BSR_LEN    = 64,
    parameter logic [IR_W-1:0] OP_EXTEST  = '0,
    parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1),
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(2),
    parameter logic [31:0]     IDCODE_VAL = 32'h0923_4001
) (
    input  logic             TCLK,
    input  logic             TRST,
    jtag_tap_param_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] RST_IR = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] RST_IR = '1;
`endif

    tap_state_e         state_q, state_d;
    logic [IR_W-1:0]    ir_sr_q, ir_sr_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic               byp_q, byp_d;
    logic [BSR_LEN-1:0] bsr_sr_q, bsr_sr_d;
    logic [BSR_LEN-1:0] bsr_upd_q, bsr_upd_d;
    logic               tdo_q, tdo_d;
    logic               tdo_en_q, tdo_en_d;
    logic               sel_bsr;
    logic               sel_id;

`ifdef JTAG_IDCODE_EN
    logic [31:0]        id_sr_q, id_sr_d;
`else
    logic               unused_idcode;
    assign unused_idcode = ^{OP_IDCODE, IDCODE_VAL};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:     state_d = jtag.TMS ? TLR    : RTI;
            RTI:     state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = jtag.TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = jtag.TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = jtag.TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = jtag.TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = jtag.TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = jtag.TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = jtag.TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = jtag.TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = jtag.TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = jtag.TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = jtag.TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = jtag.TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = jtag.TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = jtag.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Anything that is neither a boundary nor an ID opcode falls through to bypass.
    always_comb begin
        sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
        sel_id  = !sel_bsr && (ir_q == OP_IDCODE);
`else
        sel_id  = 1'b0;
`endif
    end

    always_comb begin
        ir_sr_d   = ir_sr_q;
        ir_d      = ir_q;
        byp_d     = byp_q;
        bsr_sr_d  = bsr_sr_q;
        bsr_upd_d = bsr_upd_q;
`ifdef JTAG_IDCODE_EN
        id_sr_d   = id_sr_q;
`endif
        tdo_d     = 1'b0;
        tdo_en_d  = 1'b0;
        case (state_q)
            CAP_IR: ir_sr_d = IR_W'(1);
            SH_IR: begin
                tdo_d    = ir_sr_q[0];
                tdo_en_d = 1'b1;
                ir_sr_d  = {jtag.TDI, ir_sr_q[IR_W-1:1]};
            end
            UPD_IR: ir_d = ir_sr_q;
            CAP_DR: begin
                if (sel_bsr) begin
                    bsr_sr_d = jtag.bsr_pi;
`ifdef JTAG_IDCODE_EN
                end else if (sel_id) begin
                    id_sr_d = IDCODE_VAL;
`endif
                end else begin
                    byp_d = 1'b0;
                end
            end
            SH_DR: begin
                tdo_en_d = 1'b1;
                if (sel_bsr) begin
                    tdo_d                 = bsr_sr_q[0];
                    bsr_sr_d              = bsr_sr_q >> 1;
                    bsr_sr_d[BSR_LEN-1]   = jtag.TDI;
`ifdef JTAG_IDCODE_EN
                end else if (sel_id) begin
                    tdo_d   = id_sr_q[0];
                    id_sr_d = {jtag.TDI, id_sr_q[31:1]};
`endif
                end else begin
                    tdo_d = byp_q;
                    byp_d = jtag.TDI;
                end
            end
            UPD_DR: if (sel_bsr) bsr_upd_d = bsr_sr_q;
            default: ;
        endcase
        // Test-logic-reset keeps the instruction pinned without touching the pin latches.
        if (state_q == TLR || state_d == TLR) ir_d = RST_IR;
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            state_q   <= TLR;
            ir_sr_q   <= '0;
            ir_q      <= RST_IR;
            byp_q     <= 1'b0;
            bsr_sr_q  <= '0;
            bsr_upd_q <= '0;
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
`ifdef JTAG_IDCODE_EN
            id_sr_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ir_sr_q   <= ir_sr_d;
            ir_q      <= ir_d;
            byp_q     <= byp_d;
            bsr_sr_q  <= bsr_sr_d;
            bsr_upd_q <= bsr_upd_d;
            tdo_q     <= tdo_d;
            tdo_en_q  <= tdo_en_d;
`ifdef JTAG_IDCODE_EN
            id_sr_q   <= id_sr_d;
`endif
        end
    end

    assign jtag.TDO    = tdo_q;
    assign jtag.TDO_EN = tdo_en_q;
    assign jtag.bsr_po = bsr_upd_q;
    assign jtag.bs_en  = (ir_q == OP_EXTEST);
    assign jtag.ir_out = ir_q;
    assign jtag.tap_st = state_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - directed vector bench for jtag_tap_param (IR_W=4, BSR_LEN=8)
module tb_jtag_tap_param;

    logic tclk = 1'b0;
    logic trst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_IR = 4'h2;
`else
    localparam logic [3:0] RST_IR = 4'hF;
`endif

    jtag_tap_param_if #(.IR_W(4), .BSR_LEN(8)) bus ();

    jtag_tap_param #(.IR_W(4), .BSR_LEN(8)) dut (
        .TCLK (tclk),
        .TRST (trst),
        .jtag (bus)
    );

    always #5 tclk = ~tclk;

    typedef struct {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic       chk;
        logic       tdo;
        logic       en;
    } vec_t;

    typedef struct {
        string      path;
        logic [3:0] st;
    } path_t;

    vec_t  walk_q[$];
    vec_t  pause_q[$];
    path_t paths[16];

    function automatic vec_t mkv(logic tms, logic tdi, logic [3:0] st, logic chk, logic tdo, logic en);
        vec_t v;
        v.tms = tms; v.tdi = tdi; v.st = st; v.chk = chk; v.tdo = tdo; v.en = en;
        return v;
    endfunction

    function automatic logic [3:0] hx(byte c);
        return (c >= 8'h41) ? 4'(c - 8'h37) : 4'(c - 8'h30);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tclk);
        #1;
    endtask

    task automatic do_reset();
        trst = 1'b1;
        step(1'b0, 1'b0);
        trst = 1'b0;
    endtask

    task automatic ir_scan(input logic [3:0] val, output logic [3:0] out, output logic [3:0] en);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, val[i]);
            out[i] = bus.TDO;
            en[i]  = bus.TDO_EN;
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input int n, input logic [31:0] data, output logic [31:0] out, output logic [31:0] en);
        out = '0;
        en  = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, data[i]);
            out[i] = bus.TDO;
            en[i]  = bus.TDO_EN;
        end
        step(1, 0); step(0, 0);
    endtask

    task automatic run_vecs(input string tag, input vec_t q[$]);
        foreach (q[i]) begin
            step(q[i].tms, q[i].tdi);
            check($sformatf("%s[%0d].st", tag, i), 32'(bus.tap_st), 32'(q[i].st));
            if (q[i].chk) begin
                check($sformatf("%s[%0d].tdo", tag, i), 32'(bus.TDO), 32'(q[i].tdo));
                check($sformatf("%s[%0d].en", tag, i), 32'(bus.TDO_EN), 32'(q[i].en));
            end
        end
    endtask

    initial begin
        string       walk_tms;
        string       walk_st;
        logic [3:0]  o4, e4;
        logic [31:0] o32, e32, data;

        walk_tms = "10010100100111001011011010010011110010110111";
        walk_st  = "FCC76133022157621305C74E9BB8AA9D74EA9B8DC74F";
        for (int i = 0; i < walk_tms.len(); i++)
            walk_q.push_back(mkv(walk_tms.getc(i) == "1", 1'b0, hx(walk_st.getc(i)), 1'b0, 1'b0, 1'b0));

        paths[0]  = '{"",        4'hF}; paths[1]  = '{"0",       4'hC};
        paths[2]  = '{"01",      4'h7}; paths[3]  = '{"010",     4'h6};
        paths[4]  = '{"0100",    4'h2}; paths[5]  = '{"0101",    4'h1};
        paths[6]  = '{"01010",   4'h3}; paths[7]  = '{"010101",  4'h0};
        paths[8]  = '{"01011",   4'h5}; paths[9]  = '{"011",     4'h4};
        paths[10] = '{"0110",    4'hE}; paths[11] = '{"01100",   4'hA};
        paths[12] = '{"01101",   4'h9}; paths[13] = '{"011010",  4'hB};
        paths[14] = '{"0110101", 4'h8}; paths[15] = '{"011011",  4'hD};

        pause_q.push_back(mkv(1, 0, 4'h7, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h6, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h2, 1, 0, 0));
        pause_q.push_back(mkv(0, 1, 4'h2, 1, 0, 1));
        pause_q.push_back(mkv(1, 0, 4'h1, 1, 1, 1));
        pause_q.push_back(mkv(0, 0, 4'h3, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h3, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h3, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h3, 1, 0, 0));
        pause_q.push_back(mkv(1, 0, 4'h0, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'h2, 1, 0, 0));
        pause_q.push_back(mkv(0, 1, 4'h2, 1, 0, 1));
        pause_q.push_back(mkv(1, 1, 4'h1, 1, 1, 1));
        pause_q.push_back(mkv(1, 0, 4'h5, 1, 0, 0));
        pause_q.push_back(mkv(0, 0, 4'hC, 1, 0, 0));

        bus.TMS = 1'b1;
        bus.TDI = 1'b0;
        bus.bsr_pi = 8'h00;
        do_reset();
        check("rst.tap_st", 32'(bus.tap_st), 32'hF);
        check("rst.ir_out", 32'(bus.ir_out), 32'(RST_IR));
        check("rst.tdo", 32'(bus.TDO), 0);
        check("rst.tdo_en", 32'(bus.TDO_EN), 0);
        check("rst.bsr_po", 32'(bus.bsr_po), 0);
        check("rst.bs_en", 32'(bus.bs_en), 0);

        run_vecs("walk", walk_q);

        for (int p = 0; p < 16; p++) begin
            do_reset();
            for (int k = 0; k < paths[p].path.len(); k++)
                step(paths[p].path.getc(k) == "1", 1'b0);
            check($sformatf("path%0d.st", p), 32'(bus.tap_st), 32'(paths[p].st));
            for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
            check($sformatf("tlr5_from%0d", p), 32'(bus.tap_st), 32'hF);
        end

        do_reset();
        step(0, 0);
        ir_scan(4'hF, o4, e4);
        check("ir_cap.tdo", 32'(o4), 32'h1);
        check("ir_cap.en", 32'(e4), 32'hF);
        check("ir_upd.ir_out", 32'(bus.ir_out), 32'hF);
        dr_scan(3, 32'h5, o32, e32);
        check("byp.tdo", o32, 32'h2);
        check("byp.en", e32, 32'h7);

        do_reset();
        step(0, 0);
        data = 32'hDEAD_BEEF;
        dr_scan(32, data, o32, e32);
`ifdef JTAG_IDCODE_EN
        check("idcode.tdo", o32, 32'h0923_4001);
`else
        check("rstbyp.tdo", o32, {data[30:0], 1'b0});
`endif
        check("rstdr.en", e32, 32'hFFFF_FFFF);

        bus.bsr_pi = 8'hA5;
        ir_scan(4'h1, o4, e4);
        check("sample.ir_out", 32'(bus.ir_out), 32'h1);
        dr_scan(8, 32'h3C, o32, e32);
        check("sample.tdo", o32, 32'hA5);
        check("sample.en", e32, 32'hFF);
        check("sample.bsr_po", 32'(bus.bsr_po), 32'h3C);
        check("sample.bs_en", 32'(bus.bs_en), 0);
        ir_scan(4'h0, o4, e4);
        check("extest.bs_en", 32'(bus.bs_en), 1);
        check("extest.bsr_po_hold", 32'(bus.bsr_po), 32'h3C);
        bus.bsr_pi = 8'h5A;
        dr_scan(8, 32'hC3, o32, e32);
        check("extest.tdo", o32, 32'h5A);
        check("extest.bsr_po", 32'(bus.bsr_po), 32'hC3);

        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        check("midscan.en_pre", 32'(bus.TDO_EN), 1);
        trst = 1'b1;
        step(0, 1);
        trst = 1'b0;
        check("midrst.tap_st", 32'(bus.tap_st), 32'hF);
        check("midrst.ir_out", 32'(bus.ir_out), 32'(RST_IR));
        check("midrst.tdo", 32'(bus.TDO), 0);
        check("midrst.tdo_en", 32'(bus.TDO_EN), 0);
        check("midrst.bsr_po", 32'(bus.bsr_po), 0);
        check("midrst.bs_en", 32'(bus.bs_en), 0);

        step(0, 0);
        ir_scan(4'h1, o4, e4);
        dr_scan(8, 32'h99, o32, e32);
        check("tlr_pre.bsr_po", 32'(bus.bsr_po), 32'h99);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        check("tlr.tap_st", 32'(bus.tap_st), 32'hF);
        check("tlr.ir_out", 32'(bus.ir_out), 32'(RST_IR));
        check("tlr.bsr_po_hold", 32'(bus.bsr_po), 32'h99);

        step(0, 0);
        ir_scan(4'h7, o4, e4);
        check("op7.ir_out", 32'(bus.ir_out), 32'h7);
        run_vecs("pause", pause_q);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
